io_bus_initiator: RTL and testbench
===================================

Name: io_bus_initiator

Overview:
- Bus initiator for the on-board 4-bit-address, 8-bit-data register bus used by the simple I/O peripherals (7-seg, RGB LED, timer).
- Turns a valid/ready command stream into correctly timed single-cycle cs/rw strobes and returns read data on a valid/ready response stream.
- Watches the peripheral irq line and optionally performs an automatic status read, which acknowledges a read-to-clear IRQ, independently of the command stream.
- Sits between a host-side command source (debug bridge or sequencer) and the peripheral bus.

Parameters:
- ADDR_W, 4, peripheral register address width.
- DATA_W, 8, data width.
- RD_LAT, 1, cycles from the edge that samples cs to valid peripheral read data (range 1..7).
- IRQ_ADDR, 4'h8, register read automatically on irq.
- AUTO_ACK, 1, 1 = service irq by auto-read; 0 = only flag irq_pending.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid & ready at a clk edge.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data.
- AD  out  ADDR_W  bus address.
- DO  out  DATA_W  bus write data (to peripheral DI).
- DI  in  DATA_W  bus read data (from peripheral DO).
- rw  out  1  1 = read, 0 = write.
- cs  out  1  bus select strobe.
- irq  in  1  peripheral interrupt, level, same clock domain.
- irq_pending  out  1  irq seen and not yet serviced.
- irq_event  out  1  one-cycle pulse when auto-read data is captured.
- irq_status  out  DATA_W  last auto-read value.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cs=0, rw=1, AD=0, DO=0, rsp_valid=0, rsp_rdata=0, irq_pending=0, irq_event=0, irq_status=0, cmd_ready=0 while in reset.
- All bus outputs are registered.
- cs is high for exactly one cycle per transaction. Reads have side effects (read-to-clear), so no repeated or extended strobes.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1 iff not (AUTO_ACK & irq).
  - Priority: irq auto-service over the command stream.
  - AUTO_ACK & irq: load AD=IRQ_ADDR, rw=1, cs=1, set tag=irq, go STROBE.
  - Otherwise, on cmd handshake: load AD, DO, rw=~cmd_wr, cs=1, tag=cmd, go STROBE.
- STROBE: cs drops at the next edge.
  - Write: go IDLE. Next command can be accepted the cycle after the strobe (2-cycle write throughput).
  - Read: go WAIT, counter = RD_LAT.
- WAIT: decrement the counter each cycle. At the edge where it reaches 0, capture DI.
  - tag=cmd: rsp_rdata <= DI, rsp_valid=1, go RESP.
  - tag=irq: irq_status <= DI, irq_event=1 for one cycle, irq_pending=0, go IDLE. Does not use the rsp channel.
- RESP: hold rsp_valid and rsp_rdata stable until rsp_ready, then go IDLE.
  - cmd_ready=0 throughout; irq is not serviced (at most one outstanding read).
- Read latency with RD_LAT=1: accept at edge E0; cs high in cycle E0..E1; rsp_valid high after E2.
- irq_pending:
  - Set on any cycle irq=1 in IDLE with AUTO_ACK=0, or when irq is latched during STROBE/WAIT/RESP.
  - With AUTO_ACK=0, cleared only by reset.
  - With AUTO_ACK=1, cleared by auto-read completion.
- irq is re-sampled only in IDLE. Because the auto-read clears the peripheral flag at the strobe edge, irq is low by the time IDLE is re-entered; no re-trigger.
- If irq stays high after the auto-read (new timer event), a second auto-read starts immediately. Back-to-back auto-reads are legal.
- Simultaneous cmd_valid and irq in IDLE: irq wins, cmd_ready=0, the command waits (not dropped).
- cmd_addr and cmd_wdata are sampled only at the handshake. Later changes have no effect on the bus.
- Reset asserted mid-transaction: cs falls asynchronously, the transaction is abandoned, and no response is produced.

Decomposition:
- Shared package io_bus_pkg:
  - state enum (IDLE, STROBE, WAIT, RESP),
  - tag enum (TAG_CMD, TAG_IRQ),
  - register address constants (LED7HI=1, LED7LO=2, RGB=3, TMR_MODE=8, TMR_PS_HI=9, TMR_PS_MID=10, TMR_PS_LO=11).
- Single module. No sub-module needed; the RD_LAT counter stays inline.

Test Plan:
- Write addr 1 data 8'h3C with cmd_valid held high -> exactly one cs cycle with rw=0, AD=1, DO=8'h3C; cmd_ready high again 2 cycles after the handshake.
- Read addr 9 against a responder model (RD_LAT=1, DI=8'h5A) -> cs one cycle with rw=1, AD=9; rsp_valid 2 cycles after accept with rsp_rdata=8'h5A.
- Same read with rsp_ready held low 5 cycles -> rsp_valid and data stable all 5 cycles; no cs and cmd_ready=0 meanwhile; completes on rsp_ready.
- Responder irq=1 with status 8'hC1, AUTO_ACK=1, model clears irq on read of 8 -> one read at AD=8; irq_status=8'hC1; single irq_event pulse; irq_pending 0; no rsp_valid.
- cmd_valid read and irq rise in the same IDLE cycle -> the auto-read to 8 is issued first, then the queued command; exactly two cs strobes.
- Reset pulled low in the cycle cs=1 -> cs=0 and rsp_valid=0 immediately; after release, state IDLE and cmd_ready=1.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and register map for the simple I/O peripheral bus.
package io_bus_pkg;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
    typedef enum logic {TAG_CMD, TAG_IRQ} tag_t;

    localparam logic [3:0] LED7HI     = 4'd1;
    localparam logic [3:0] LED7LO     = 4'd2;
    localparam logic [3:0] RGB        = 4'd3;
    localparam logic [3:0] TMR_MODE   = 4'd8;
    localparam logic [3:0] TMR_PS_HI  = 4'd9;
    localparam logic [3:0] TMR_PS_MID = 4'd10;
    localparam logic [3:0] TMR_PS_LO  = 4'd11;

endpackage

// File: rtl/io_bus_initiator_if.sv
// Command/response streams plus peripheral bus and irq signals of the initiator.
interface io_bus_initiator_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] AD;
    logic [DATA_W-1:0] DO;
    logic [DATA_W-1:0] DI;
    logic              rw;
    logic              cs;
    logic              irq;
    logic              irq_pending;
    logic              irq_event;
    logic [DATA_W-1:0] irq_status;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, DI, irq,
        output cmd_ready, rsp_valid, rsp_rdata, AD, DO, rw, cs,
               irq_pending, irq_event, irq_status
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, DI, irq,
        input  cmd_ready, rsp_valid, rsp_rdata, AD, DO, rw, cs,
               irq_pending, irq_event, irq_status
    );
endinterface

// File: rtl/io_bus_initiator.sv
// Register-bus initiator: one registered cs strobe per command, read data back on a
// response stream, and optional automatic status read to acknowledge peripheral irq.
module io_bus_initiator
    import io_bus_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(8),
    parameter bit                AUTO_ACK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    io_bus_initiator_if.master bus
);

    state_t            state, state_n;
    tag_t              tag, tag_n;
    logic [2:0]        cnt, cnt_n;
    logic              cs_q, cs_n;
    logic              rw_q, rw_n;
    logic [ADDR_W-1:0] ad_q, ad_n;
    logic [DATA_W-1:0] do_q, do_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
    logic              pend_q, pend_n;
    logic              evt_q, evt_n;
    logic [DATA_W-1:0] stat_q, stat_n;
    logic              irq_svc;
    logic              ready_c;

    assign irq_svc = AUTO_ACK && bus.irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tag         <= TAG_CMD;
            cnt         <= '0;
            cs_q        <= 1'b0;
            rw_q        <= 1'b1;
            ad_q        <= '0;
            do_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            pend_q      <= 1'b0;
            evt_q       <= 1'b0;
            stat_q      <= '0;
        end else begin
            state       <= state_n;
            tag         <= tag_n;
            cnt         <= cnt_n;
            cs_q        <= cs_n;
            rw_q        <= rw_n;
            ad_q        <= ad_n;
            do_q        <= do_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            pend_q      <= pend_n;
            evt_q       <= evt_n;
            stat_q      <= stat_n;
        end
    end

    always_comb begin
        state_n     = state;
        tag_n       = tag;
        cnt_n       = cnt;
        cs_n        = 1'b0;
        rw_n        = rw_q;
        ad_n        = ad_q;
        do_n        = do_q;
        rsp_valid_n = rsp_valid_q;
        rsp_rdata_n = rsp_rdata_q;
        pend_n      = pend_q;
        evt_n       = 1'b0;
        stat_n      = stat_q;
        ready_c     = 1'b0;
        // irq seen anywhere marks pending; only a completed auto-read clears it
        if (bus.irq) pend_n = 1'b1;
        case (state)
            IDLE: begin
                ready_c = rst && !irq_svc;
                if (irq_svc) begin
                    ad_n    = IRQ_ADDR;
                    rw_n    = 1'b1;
                    cs_n    = 1'b1;
                    tag_n   = TAG_IRQ;
                    state_n = STROBE;
                end else if (bus.cmd_valid) begin
                    ad_n    = bus.cmd_addr;
                    do_n    = bus.cmd_wdata;
                    rw_n    = !bus.cmd_wr;
                    cs_n    = 1'b1;
                    tag_n   = TAG_CMD;
                    state_n = STROBE;
                end
            end
            STROBE: begin
                if (rw_q) begin
                    cnt_n   = 3'(RD_LAT);
                    state_n = WAIT;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    if (tag == TAG_IRQ) begin
                        stat_n  = bus.DI;
                        evt_n   = 1'b1;
                        pend_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        rsp_rdata_n = bus.DI;
                        rsp_valid_n = 1'b1;
                        state_n     = RESP;
                    end
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cmd_ready   = ready_c;
    assign bus.cs          = cs_q;
    assign bus.rw          = rw_q;
    assign bus.AD          = ad_q;
    assign bus.DO          = do_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.irq_pending = pend_q;
    assign bus.irq_event   = evt_q;
    assign bus.irq_status  = stat_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench for io_bus_initiator against a small register-file responder (RD_LAT=1).
module tb_io_bus_initiator;
    import io_bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq_raise = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    io_bus_initiator_if #(.ADDR_W(4), .DATA_W(8)) bif ();

    io_bus_initiator #(
        .ADDR_W(4), .DATA_W(8), .RD_LAT(1), .IRQ_ADDR(4'h8), .AUTO_ACK(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // Responder: writes land on the strobe edge, read data is valid one cycle later,
    // and reading TMR_MODE clears the irq flag (read-to-clear).
    logic [7:0] regs [16];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
            regs[TMR_MODE]  <= 8'hC1;
            regs[TMR_PS_HI] <= 8'h5A;
            regs[LED7LO]    <= 8'h77;
            bif.DI  <= 8'h00;
            bif.irq <= 1'b0;
        end else begin
            if (bif.cs && !bif.rw) regs[bif.AD] <= bif.DO;
            if (bif.cs && bif.rw) begin
                bif.DI <= regs[bif.AD];
                if (bif.AD == TMR_MODE) bif.irq <= 1'b0;
            end
            if (irq_raise) bif.irq <= 1'b1;
        end
    end

    int         cs_total = 0;
    int         evt_total = 0;
    int         rsp_total = 0;
    logic [3:0] ad_hist [64];
    always @(posedge clk) begin
        if (bif.cs) begin
            ad_hist[cs_total & 63] <= bif.AD;
            cs_total <= cs_total + 1;
        end
        if (bif.irq_event) evt_total <= evt_total + 1;
        if (bif.rsp_valid) rsp_total <= rsp_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int         base, ebase, rbase;
    logic       got_rsp;
    logic [7:0] rd;

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_wr    = 1'b0;
        bif.cmd_addr  = 4'h0;
        bif.cmd_wdata = 8'h00;
        bif.rsp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cs", 32'(bif.cs), 0);
        chk("rst_rw", 32'(bif.rw), 1);
        chk("rst_ad", 32'(bif.AD), 0);
        chk("rst_do", 32'(bif.DO), 0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bif.rsp_rdata), 0);
        chk("rst_irq_pending", 32'(bif.irq_pending), 0);
        chk("rst_irq_event", 32'(bif.irq_event), 0);
        chk("rst_irq_status", 32'(bif.irq_status), 0);
        chk("rst_cmd_ready", 32'(bif.cmd_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(bif.cmd_ready), 1);

        // write LED7HI <= 3C, valid held through the strobe
        base = cs_total;
        bif.cmd_valid = 1'b1; bif.cmd_wr = 1'b1;
        bif.cmd_addr = LED7HI; bif.cmd_wdata = 8'h3C;
        @(negedge clk);
        chk("wr_cs", 32'(bif.cs), 1);
        chk("wr_rw", 32'(bif.rw), 0);
        chk("wr_ad", 32'(bif.AD), 1);
        chk("wr_do", 32'(bif.DO), 32'h3C);
        chk("wr_rdy_strobe", 32'(bif.cmd_ready), 0);
        bif.cmd_addr = 4'h5; bif.cmd_wdata = 8'hFF;
        @(negedge clk);
        chk("wr_cs_drop", 32'(bif.cs), 0);
        chk("wr_rdy_again", 32'(bif.cmd_ready), 1);
        chk("wr_ad_hold", 32'(bif.AD), 1);
        chk("wr_do_hold", 32'(bif.DO), 32'h3C);
        bif.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_cs_count", 32'(cs_total - base), 1);
        chk("wr_reg", 32'(regs[LED7HI]), 32'h3C);

        // read TMR_PS_HI, consumer ready
        base = cs_total;
        bif.cmd_valid = 1'b1; bif.cmd_wr = 1'b0; bif.cmd_addr = TMR_PS_HI;
        @(negedge clk);
        chk("rd_cs", 32'(bif.cs), 1);
        chk("rd_rw", 32'(bif.rw), 1);
        chk("rd_ad", 32'(bif.AD), 9);
        chk("rd_rsp_early0", 32'(bif.rsp_valid), 0);
        bif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rd_cs_drop", 32'(bif.cs), 0);
        chk("rd_rsp_early1", 32'(bif.rsp_valid), 0);
        @(negedge clk);
        chk("rd_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("rd_rsp_rdata", 32'(bif.rsp_rdata), 32'h5A);
        @(negedge clk);
        chk("rd_rsp_done", 32'(bif.rsp_valid), 0);
        chk("rd_rdy_after", 32'(bif.cmd_ready), 1);
        chk("rd_cs_count", 32'(cs_total - base), 1);

        // read with response back-pressure
        base = cs_total;
        bif.rsp_ready = 1'b0;
        bif.cmd_valid = 1'b1; bif.cmd_wr = 1'b0; bif.cmd_addr = TMR_PS_HI;
        @(negedge clk);
        bif.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bif.rsp_valid), 1);
            chk("bp_rsp_rdata", 32'(bif.rsp_rdata), 32'h5A);
            chk("bp_cs", 32'(bif.cs), 0);
            chk("bp_cmd_ready", 32'(bif.cmd_ready), 0);
            @(negedge clk);
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_done", 32'(bif.rsp_valid), 0);
        chk("bp_cs_count", 32'(cs_total - base), 1);

        // irq auto-acknowledge read
        base = cs_total; ebase = evt_total; rbase = rsp_total;
        irq_raise = 1'b1;
        @(negedge clk);
        irq_raise = 1'b0;
        chk("irq_cmd_ready", 32'(bif.cmd_ready), 0);
        @(negedge clk);
        chk("irq_cs", 32'(bif.cs), 1);
        chk("irq_ad", 32'(bif.AD), 8);
        chk("irq_rw", 32'(bif.rw), 1);
        chk("irq_pend_set", 32'(bif.irq_pending), 1);
        @(negedge clk);
        chk("irq_cs_drop", 32'(bif.cs), 0);
        @(negedge clk);
        chk("irq_event", 32'(bif.irq_event), 1);
        chk("irq_status", 32'(bif.irq_status), 32'hC1);
        chk("irq_pend_clr", 32'(bif.irq_pending), 0);
        @(negedge clk);
        chk("irq_event_pulse", 32'(bif.irq_event), 0);
        chk("irq_event_count", 32'(evt_total - ebase), 1);
        chk("irq_no_rsp", 32'(rsp_total - rbase), 0);
        chk("irq_cs_count", 32'(cs_total - base), 1);
        chk("irq_line_low", 32'(bif.irq), 0);
        chk("irq_rdy_after", 32'(bif.cmd_ready), 1);

        // command and irq arrive in the same idle cycle
        base = cs_total;
        irq_raise = 1'b1;
        @(posedge clk);
        #1;
        irq_raise = 1'b0;
        bif.cmd_valid = 1'b1; bif.cmd_wr = 1'b0; bif.cmd_addr = LED7LO;
        @(negedge clk);
        chk("race_cmd_ready", 32'(bif.cmd_ready), 0);
        got_rsp = 1'b0;
        rd = 8'h00;
        for (int i = 0; i < 30 && !got_rsp; i++) begin
            @(negedge clk);
            if (bif.cs && bif.AD == LED7LO) bif.cmd_valid = 1'b0;
            if (bif.rsp_valid) begin
                got_rsp = 1'b1;
                rd = bif.rsp_rdata;
            end
        end
        bif.cmd_valid = 1'b0;
        chk("race_rsp_seen", 32'(got_rsp), 1);
        chk("race_rsp_rdata", 32'(rd), 32'h77);
        chk("race_cs_count", 32'(cs_total - base), 2);
        chk("race_first_ad", 32'(ad_hist[base & 63]), 8);
        chk("race_second_ad", 32'(ad_hist[(base + 1) & 63]), 2);
        chk("race_irq_status", 32'(bif.irq_status), 32'hC1);
        chk("race_irq_pend", 32'(bif.irq_pending), 0);
        @(negedge clk);

        // reset asserted while cs is high
        bif.cmd_valid = 1'b1; bif.cmd_wr = 1'b0; bif.cmd_addr = TMR_PS_HI;
        @(posedge clk);
        #1;
        bif.cmd_valid = 1'b0;
        chk("mid_cs_before", 32'(bif.cs), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_cs_async", 32'(bif.cs), 0);
        chk("mid_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("mid_cmd_ready", 32'(bif.cmd_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        rbase = rsp_total;
        repeat (4) @(negedge clk);
        chk("post_no_rsp", 32'(rsp_total - rbase), 0);
        chk("post_cs", 32'(bif.cs), 0);
        chk("post_cmd_ready", 32'(bif.cmd_ready), 1);
        chk("post_rw", 32'(bif.rw), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
